// File: rtl/sample_stream_pkg.sv
// Shared defaults, sizing helper and beat type for the sample stream FIFO.
package sample_stream_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 4;
    localparam int DEFAULT_STAT_WIDTH = 16;

    // Address width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } stream_beat_t;

endpackage

// File: rtl/sample_stream_ram.sv
// DEPTH x DATA_WIDTH beat storage: one synchronous write port, one asynchronous read port.
module sample_stream_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_stream_fifo.sv
// Valid/ready stream FIFO with registered head-of-queue output and fill level.
// Optional beat counters are enabled by defining SAMPLE_STREAM_FIFO_STATS_EN.
module sample_stream_fifo
    import sample_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int STAT_WIDTH = DEFAULT_STAT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stream_in_valid,
    output logic                    stream_in_ready,
    input  logic [DATA_WIDTH-1:0]   stream_in_data,
    output logic                    stream_out_valid,
    input  logic                    stream_out_ready,
    output logic [DATA_WIDTH-1:0]   stream_out_data,
    output logic [$clog2(DEPTH):0]  level
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]   beats_in,
    output logic [STAT_WIDTH-1:0]   beats_out
`endif
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sample_stream_fifo: DEPTH must be a power of two in 2..256");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 128 || STAT_WIDTH < 1) begin : g_bad_width
        $error("sample_stream_fifo: DATA_WIDTH or STAT_WIDTH out of range");
    end

    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_inc;
    logic [LVL_W-1:0]      level_reg, level_next;
    logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  full, empty, push, pop;

    assign full  = (level_reg == LVL_W'(DEPTH));
    assign empty = (level_reg == '0);

    // Ready depends only on registered level, so a pop cannot open a slot in the same cycle.
    assign stream_in_ready  = !full;
    assign stream_out_valid = !empty;
    assign stream_out_data  = out_data_reg;
    assign level            = level_reg;

    assign push       = stream_in_valid & stream_in_ready & !rst;
    assign pop        = stream_out_valid & stream_out_ready & !rst;
    assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

    sample_stream_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (stream_in_data),
        .rd_addr (rd_ptr_inc),
        .rd_data (ram_rd_data)
    );

    // The output register mirrors the RAM entry at rd_ptr; the incoming beat bypasses
    // the RAM when it becomes the new head in the same edge it is written.
    always_comb begin
        out_data_next = out_data_reg;
        if (pop) begin
            if (level_reg == LVL_W'(1)) begin
                if (push) begin
                    out_data_next = stream_in_data;
                end
            end else begin
                out_data_next = ram_rd_data;
            end
        end else if (empty && push) begin
            out_data_next = stream_in_data;
        end
    end

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            out_data_reg <= '0;
        end else begin
            level_reg    <= level_next;
            out_data_reg <= out_data_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
        end
    end

`ifdef SAMPLE_STREAM_FIFO_STATS_EN
    logic [STAT_WIDTH-1:0] beats_in_reg, beats_out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_in_reg  <= '0;
            beats_out_reg <= '0;
        end else begin
            if (push) begin
                beats_in_reg <= beats_in_reg + STAT_WIDTH'(1);
            end
            if (pop) begin
                beats_out_reg <= beats_out_reg + STAT_WIDTH'(1);
            end
        end
    end

    assign beats_in  = beats_in_reg;
    assign beats_out = beats_out_reg;
`endif

endmodule
